// File: rtl/fork_n_pkg.sv
// Shared types and helpers for the N-way Avalon-ST packet fork.
package fork_n_pkg;

    localparam int STATS_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } fork_state_t;

    // Out-of-range routes collapse onto the last output.
    function automatic int sat_route(input int route, input int n_out);
        return (route < n_out) ? route : n_out - 1;
    endfunction

    function automatic int stats_lsb(input int k);
        return k * STATS_W;
    endfunction

endpackage

// File: rtl/stats_cnt32.sv
// Wrapping statistics counter; clear has priority over increment.
module stats_cnt32
    import fork_n_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [STATS_W-1:0] cnt
);

    logic [STATS_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (inc) begin
            cnt_reg <= cnt_reg + STATS_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/fork_n_avlstrm.sv
// N-way Avalon-ST packet fork with per-packet routing and one registered output stage.
// Build with FORK_N_DROP_EN to discard packets whose route is out of range.
module fork_n_avlstrm
    import fork_n_pkg::*;
#(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6,
    parameter int N_OUT   = 4,
    parameter int ROUTE_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [EMPTY_W-1:0]       in_empty,
    input  logic [ROUTE_W-1:0]       in_route,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [EMPTY_W-1:0]       out_empty,
    output logic [N_OUT-1:0]         out_valid,
    input  logic [N_OUT-1:0]         out_ready,
    input  logic                     stats_clr,
    output logic [N_OUT*STATS_W-1:0] stats_pkt,
    output logic [N_OUT*STATS_W-1:0] stats_sop,
    output logic [STATS_W-1:0]       stats_err,
    output logic [STATS_W-1:0]       stats_drop
);

    localparam int DST_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    fork_state_t         state_reg, state_next;
    logic [DST_W-1:0]    route_reg, route_next;
    logic [DST_W-1:0]    route_sat, dst_sel;
    logic                hv_reg;
    logic [DST_W-1:0]    hdst_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                sop_reg, eop_reg;
    logic [EMPTY_W-1:0]  empty_reg;
    logic                accept, fwd, err_inc, drop_inc;

    assign route_sat = DST_W'(sat_route(int'(in_route), N_OUT));

`ifdef FORK_N_DROP_EN
    logic route_oor;
    assign route_oor = (int'(in_route) >= N_OUT);
    // Non-SOP beats in DROP never reach the output stage, so they need no space there.
    assign in_ready = ~hv_reg | out_ready[hdst_reg] | ((state_reg == DROP) & ~in_sop);
`else
    assign in_ready = ~hv_reg | out_ready[hdst_reg];
`endif

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            route_reg <= '0;
        end else begin
            state_reg <= state_next;
            route_reg <= route_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        route_next = route_reg;
        dst_sel    = route_reg;
        fwd        = 1'b0;
        err_inc    = 1'b0;
        drop_inc   = 1'b0;
        if (accept) begin
            if (in_sop) begin
                // A SOP anywhere but IDLE means the previous packet lost its EOP.
                err_inc = (state_reg != IDLE);
`ifdef FORK_N_DROP_EN
                if (route_oor) begin
                    drop_inc   = 1'b1;
                    state_next = in_eop ? IDLE : DROP;
                end else
`endif
                begin
                    fwd        = 1'b1;
                    route_next = route_sat;
                    dst_sel    = route_sat;
                    state_next = in_eop ? IDLE : PKT;
                end
            end else begin
                case (state_reg)
                    PKT: begin
                        fwd = 1'b1;
                        if (in_eop) state_next = IDLE;
                    end
                    DROP: begin
                        if (in_eop) state_next = IDLE;
                    end
                    default: err_inc = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hv_reg    <= 1'b0;
            hdst_reg  <= '0;
            data_reg  <= '0;
            sop_reg   <= 1'b0;
            eop_reg   <= 1'b0;
            empty_reg <= '0;
        end else if (fwd) begin
            hv_reg    <= 1'b1;
            hdst_reg  <= dst_sel;
            data_reg  <= in_data;
            sop_reg   <= in_sop;
            eop_reg   <= in_eop;
            empty_reg <= in_empty;
        end else if (hv_reg && out_ready[hdst_reg]) begin
            hv_reg <= 1'b0;
        end
    end

    assign out_data  = data_reg;
    assign out_sop   = sop_reg;
    assign out_eop   = eop_reg;
    assign out_empty = empty_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_out
            logic fire;
            assign out_valid[gi] = hv_reg && (hdst_reg == DST_W'(gi));
            assign fire          = out_valid[gi] & out_ready[gi];

            stats_cnt32 u_pkt_cnt (
                .clk (clk),
                .rst (rst),
                .clr (stats_clr),
                .inc (fire & eop_reg),
                .cnt (stats_pkt[stats_lsb(gi) +: STATS_W])
            );

            stats_cnt32 u_sop_cnt (
                .clk (clk),
                .rst (rst),
                .clr (stats_clr),
                .inc (fire & sop_reg),
                .cnt (stats_sop[stats_lsb(gi) +: STATS_W])
            );
        end
    endgenerate

    stats_cnt32 u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (err_inc),
        .cnt (stats_err)
    );

    // drop_inc is constant zero unless the drop feature is built in.
    stats_cnt32 u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .clr (stats_clr),
        .inc (drop_inc),
        .cnt (stats_drop)
    );

endmodule

// File: tb/tb_fork_n_avlstrm.sv
// Directed self-checking bench for fork_n_avlstrm (N_OUT=4, narrow data bus).
module tb_fork_n_avlstrm;

    localparam int DATA_W  = 32;
    localparam int EMPTY_W = 2;
    localparam int N_OUT   = 4;
    localparam int ROUTE_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DATA_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sop;
    logic                   in_eop;
    logic [EMPTY_W-1:0]     in_empty;
    logic [ROUTE_W-1:0]     in_route;
    logic [DATA_W-1:0]      out_data;
    logic                   out_sop;
    logic                   out_eop;
    logic [EMPTY_W-1:0]     out_empty;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic                   stats_clr;
    logic [N_OUT*32-1:0]    stats_pkt;
    logic [N_OUT*32-1:0]    stats_sop;
    logic [31:0]            stats_err;
    logic [31:0]            stats_drop;

    fork_n_avlstrm #(
        .DATA_W  (DATA_W),
        .EMPTY_W (EMPTY_W),
        .N_OUT   (N_OUT),
        .ROUTE_W (ROUTE_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .in_empty   (in_empty),
        .in_route   (in_route),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_empty  (out_empty),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .stats_clr  (stats_clr),
        .stats_pkt  (stats_pkt),
        .stats_sop  (stats_sop),
        .stats_err  (stats_err),
        .stats_drop (stats_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        sop;
        logic        eop;
        int          cyc;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    beat_t got_q[$];
    int    acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Every completed output handshake, observed mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < N_OUT; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                got_q.push_back('{k, out_data, out_sop, out_eop, cyc});
                $display("beat port=%0d data=%08h sop=%0b eop=%0b cyc=%0d", k, out_data, out_sop, out_eop, cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [3:0] r);
        int n = 0;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_route = r;
        in_empty = d[1:0];
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 64'(in_ready), 64'd1);
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        got_q.delete();
        acc_q.delete();
    endtask

    function automatic logic [31:0] slc(input logic [N_OUT*32-1:0] v, input int k);
        return v[k*32 +: 32];
    endfunction

    int          exp_port [9] = '{0, 0, 0, 2, 2, 2, 3, 3, 3};
    logic [31:0] exp_data [9] = '{32'h100, 32'h101, 32'h102, 32'h300, 32'h301, 32'h302,
                                  32'h400, 32'h401, 32'h402};
    int          t3_port  [4] = '{0, 0, 2, 2};
    logic [31:0] t3_data  [4] = '{32'h610, 32'h611, 32'h620, 32'h621};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_empty  = '0;
        in_route  = '0;
        out_ready = '1;
        stats_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_stats_pkt", 64'(|stats_pkt), 64'd0);
        chk("rst_stats_err", 64'(stats_err), 64'd0);
        chk("rst_stats_drop", 64'(stats_drop), 64'd0);
        @(posedge clk);
        #1;

        // Three 3-beat packets to outputs 0, 2, 3, all ready
        clr_stats();
        send(32'h100, 1, 0, 0); send(32'h101, 0, 0, 1); send(32'h102, 0, 1, 3);
        send(32'h300, 1, 0, 2); send(32'h301, 0, 0, 0); send(32'h302, 0, 1, 0);
        send(32'h400, 1, 0, 3); send(32'h401, 0, 0, 2); send(32'h402, 0, 1, 2);
        drain();
        chk("t1_count", 64'(got_q.size()), 64'd9);
        for (int k = 0; k < 9 && k < got_q.size(); k++) begin
            chk($sformatf("t1_port%0d", k), 64'(got_q[k].port), 64'(exp_port[k]));
            chk($sformatf("t1_data%0d", k), 64'(got_q[k].data), 64'(exp_data[k]));
            chk($sformatf("t1_sop%0d", k), 64'(got_q[k].sop), 64'((k % 3) == 0));
            chk($sformatf("t1_eop%0d", k), 64'(got_q[k].eop), 64'((k % 3) == 2));
            chk($sformatf("t1_lat%0d", k), 64'(got_q[k].cyc), 64'(acc_q[k] + 1));
        end
        chk("t1_pkt0", 64'(slc(stats_pkt, 0)), 64'd1);
        chk("t1_pkt1", 64'(slc(stats_pkt, 1)), 64'd0);
        chk("t1_pkt2", 64'(slc(stats_pkt, 2)), 64'd1);
        chk("t1_pkt3", 64'(slc(stats_pkt, 3)), 64'd1);
        chk("t1_sop0", 64'(slc(stats_sop, 0)), 64'd1);
        chk("t1_sop1", 64'(slc(stats_sop, 1)), 64'd0);
        chk("t1_sop2", 64'(slc(stats_sop, 2)), 64'd1);
        chk("t1_sop3", 64'(slc(stats_sop, 3)), 64'd1);
        chk("t1_err", 64'(stats_err), 64'd0);

        // Output 1 stalled for 5 cycles mid-packet
        clr_stats();
        send(32'h500, 1, 0, 1);
        out_ready[1] = 1'b0;
        fork
            begin
                send(32'h501, 0, 0, 1);
                send(32'h502, 0, 0, 1);
                send(32'h503, 0, 1, 1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk($sformatf("t2_in_ready%0d", i), 64'(in_ready), 64'd0);
                    chk($sformatf("t2_hold_data%0d", i), 64'(out_data), 64'h500);
                    chk($sformatf("t2_hold_valid%0d", i), 64'(out_valid), 64'b0010);
                end
                @(posedge clk);
                #1;
                out_ready[1] = 1'b1;
            end
        join
        drain();
        chk("t2_count", 64'(got_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            chk($sformatf("t2_data%0d", k), 64'(got_q[k].data), 64'(32'h500 + k));
            chk($sformatf("t2_port%0d", k), 64'(got_q[k].port), 64'd1);
            chk($sformatf("t2_cyc%0d", k), 64'(got_q[k].cyc), 64'(got_q[0].cyc + k));
        end
        chk("t2_pkt1", 64'(slc(stats_pkt, 1)), 64'd1);

        // Stray non-SOP in IDLE, then SOP without EOP followed by a new SOP
        clr_stats();
        send(32'h600, 0, 0, 2);
        send(32'h610, 1, 0, 0);
        send(32'h611, 0, 0, 3);
        send(32'h620, 1, 0, 2);
        send(32'h621, 0, 1, 0);
        drain();
        chk("t3_err", 64'(stats_err), 64'd2);
        chk("t3_count", 64'(got_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            chk($sformatf("t3_port%0d", k), 64'(got_q[k].port), 64'(t3_port[k]));
            chk($sformatf("t3_data%0d", k), 64'(got_q[k].data), 64'(t3_data[k]));
        end
        chk("t3_pkt0", 64'(slc(stats_pkt, 0)), 64'd0);
        chk("t3_sop0", 64'(slc(stats_sop, 0)), 64'd1);
        chk("t3_pkt2", 64'(slc(stats_pkt, 2)), 64'd1);

        // Out-of-range route
        clr_stats();
        send(32'h700, 1, 0, 9);
        send(32'h701, 0, 1, 9);
        drain();
`ifdef FORK_N_DROP_EN
        chk("t4_count", 64'(got_q.size()), 64'd0);
        chk("t4_drop", 64'(stats_drop), 64'd1);
        chk("t4_pkt3", 64'(slc(stats_pkt, 3)), 64'd0);
`else
        chk("t4_count", 64'(got_q.size()), 64'd2);
        for (int k = 0; k < 2 && k < got_q.size(); k++) begin
            chk($sformatf("t4_port%0d", k), 64'(got_q[k].port), 64'd3);
        end
        chk("t4_pkt3", 64'(slc(stats_pkt, 3)), 64'd1);
        chk("t4_drop", 64'(stats_drop), 64'd0);
`endif
        chk("t4_err", 64'(stats_err), 64'd0);

        // Counter wrap and clear-beats-increment
        clr_stats();
        dut.g_out[0].u_pkt_cnt.cnt_reg = 32'hFFFF_FFFF;
        send(32'h800, 1, 1, 0);
        drain();
        chk("t5_wrap_pkt0", 64'(slc(stats_pkt, 0)), 64'd0);
        chk("t5_wrap_sop0", 64'(slc(stats_sop, 0)), 64'd1);
        send(32'h801, 1, 1, 0);
        drain();
        chk("t5_inc_pkt0", 64'(slc(stats_pkt, 0)), 64'd1);
        chk("t5_inc_sop0", 64'(slc(stats_sop, 0)), 64'd2);
        send(32'h802, 1, 1, 0);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        @(negedge clk);
        chk("t5_clr_pkt0", 64'(slc(stats_pkt, 0)), 64'd0);
        chk("t5_clr_sop0", 64'(slc(stats_sop, 0)), 64'd0);
        chk("t5_clr_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset mid-packet, then a non-SOP beat
        send(32'h8FF, 1, 1, 1);
        drain();
        chk("t6_pre_pkt1", 64'(slc(stats_pkt, 1)), 64'd1);
        send(32'h900, 1, 0, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_out_data", 64'(out_data), 64'd0);
        chk("t6_out_sop", 64'(out_sop), 64'd0);
        chk("t6_out_eop", 64'(out_eop), 64'd0);
        chk("t6_out_empty", 64'(out_empty), 64'd0);
        chk("t6_stats_pkt", 64'(|stats_pkt), 64'd0);
        chk("t6_stats_sop", 64'(|stats_sop), 64'd0);
        chk("t6_stats_err", 64'(stats_err), 64'd0);
        @(posedge clk);
        #1;
        got_q.delete();
        send(32'h910, 0, 0, 1);
        drain();
        chk("t6_err", 64'(stats_err), 64'd1);
        chk("t6_count", 64'(got_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fork_n_avlstrm.md
Name: fork_n_avlstrm

Overview:
- Parametrised N-way Avalon-ST packet fork; generalises the fixed 2-way nocheck/check split at the string-matcher output.
- Route is sampled per packet on the SOP beat and held through EOP; beats go to exactly one of N_OUT outputs through one registered output stage.
- Keeps per-output packet/SOP counters plus protocol-error counters for the stats packer.
- Sits in the back clock domain between the matcher and the downstream fast-path and check paths.

Parameters:
- DATA_W, 512: beat data width.
- EMPTY_W, 6: empty-byte field width, sized for DATA_W/8.
- N_OUT, 4: number of outputs, 2..16.
- ROUTE_W, 4: route selector width; must satisfy 2**ROUTE_W >= N_OUT.

Ports:
- Clk  in  1  single clock.
- Rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  input beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_empty  in  EMPTY_W  empty bytes, meaningful on EOP.
- in_route  in  ROUTE_W  destination index, sampled on SOP beats only.
- out_data  out  DATA_W  shared data bus to all outputs.
- out_sop  out  1  shared SOP.
- out_eop  out  1  shared EOP.
- out_empty  out  EMPTY_W  shared empty field.
- out_valid  out  N_OUT  one-hot or zero.
- out_ready  in  N_OUT  per-output ready.
- stats_clr  in  1  synchronous clear of all counters.
- stats_pkt  out  N_OUT*32  EOP beats delivered per output; slice k = output k.
- stats_sop  out  N_OUT*32  SOP beats delivered per output.
- stats_err  out  32  protocol errors.
- stats_drop  out  32  dropped packets; stays 0 unless DROP_EN.

Behaviour:
- Ready latency is 0 on all ports.
- Output register: held beat (hv, hdst).
  - in_ready = ~hv | out_ready[hdst].
  - out_valid = hv ? onehot(hdst) : 0.
- Input-to-output latency is 1 cycle. Full throughput: 1 beat/cycle when the target output is always ready.
- Data, sop, eop and empty are registered on accept. Held-register contents stay stable while out_valid is set and out_ready is low.
- State machine, advanced on each accepted beat:
  - IDLE, sop=1: route r = sat(in_route). Go to PKT, or stay IDLE if eop=1.
  - IDLE, sop=0: stats_err += 1. Beat is consumed and discarded (not forwarded); stay IDLE.
  - PKT, sop=0: forward to the locked route. eop=1 -> IDLE.
  - PKT, sop=1 (missing EOP): stats_err += 1. Re-sample the route and forward as a new packet. No synthetic EOP is inserted.
- sat(x) = x if x < N_OUT, else N_OUT-1.
- Counters:
  - 32-bit, wrap modulo 2**32.
  - stats_pkt[k] and stats_sop[k] increment when an output-k handshake completes (out_valid[k] & out_ready[k]) with eop/sop set.
  - A single-beat packet increments both.
  - stats_clr and an increment in the same cycle: clear wins, result 0.
- Reset:
  - hv=0, out_valid=0, state=IDLE, all counters 0, out_data/sop/eop/empty=0.
  - A packet in flight during reset is abandoned; the next beat must be SOP, else it counts as an error.
- Idle inputs (in_valid=0) change nothing. in_route on non-SOP beats is ignored.

Optional Feature:
- Macro: FORK_N_DROP_EN.
- Defined:
  - SOP with in_route >= N_OUT enters DROP (or stays IDLE if eop=1); stats_drop += 1.
  - In DROP, in_ready=1 and beats are discarded until EOP, then IDLE.
  - SOP in DROP: stats_err += 1, then handled as an IDLE SOP.
- Undefined: saturation to N_OUT-1 as above, no DROP state, stats_drop tied to 0.

Decomposition:
- Package fork_n_pkg:
  - state enum {IDLE, PKT, DROP}.
  - STATS_W=32.
  - function sat_route.
  - stats slice index helper.
- Sub-module stats_cnt32: 32-bit counter with inc, clr (priority) and synchronous active-high reset. Instantiated 2*N_OUT+2 times.

Test Plan:
- N_OUT=4; three packets of 3 beats routed 0,2,3; all ready=1.
  - Each beat appears on the matching out_valid bit one cycle after accept.
  - stats_pkt = {1,0,1,1}; stats_sop likewise.
- Route 1 packet; out_ready[1]=0 for 5 cycles mid-packet.
  - Held beat stable and in_ready=0 throughout; no beat lost or duplicated.
  - Throughput returns to 1/cycle after release.
- Non-SOP beat in IDLE, then SOP-without-EOP followed by a new SOP.
  - stats_err=2; first beat not forwarded; second packet goes to its new route.
- in_route=9 with N_OUT=4.
  - Without macro: packet on output 3, stats_pkt[3]=1.
  - With FORK_N_DROP_EN: all beats accepted, no out_valid, stats_drop=1.
- stats_pkt[0] preset near wrap by driving 2**32-1 EOPs (forced), then one more.
  - Reads 0; stats_clr asserted in the same cycle as an EOP yields 0.
- Rst asserted mid-packet, then a non-SOP beat.
  - All outputs and counters 0 after reset; stats_err=1 after the beat.
